// File: rtl/coherence_bus_ctrl_pkg.sv
// coherence_bus_ctrl_pkg: shared types and sizes for the MSI bus controller
package coherence_bus_ctrl_pkg;
    localparam int CPUS     = 2;
    localparam int BLKWORDS = 2;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [2:0] {IDLE, SNOOP, SWB, FILL, PLAIN} bus_state_t;
endpackage

// File: rtl/coherence_bus_ctrl_arb.sv
// rr_arbiter_2: two-way round-robin grant where coherent requests outrank plain ones
// Ports: CLK/RST clock and sync reset; en commits the grant (updates lastgrant);
// creq/preq coherent and plain requests; gnt_valid/gnt_id/gnt_coh the grant.
module rr_arbiter_2 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       en,
    input  logic [1:0] creq,
    input  logic [1:0] preq,
    output logic       gnt_valid,
    output logic       gnt_id,
    output logic       gnt_coh
);
    logic       lastgrant;
    logic [1:0] req;
    assign gnt_coh   = |creq;
    assign req       = gnt_coh ? creq : preq;
    assign gnt_valid = |req;
    assign gnt_id    = (&req) ? ~lastgrant : req[1];
    always_ff @(posedge CLK)
        if (RST) lastgrant <= 1'b0;
        else if (en && gnt_valid) lastgrant <= gnt_id;
endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: bus-side MSI snoop responder muxing two dcaches onto one RAM port
// Ports: CLK/RST clock and sync active-high reset; dREN/dWEN/daddr/dstore per-cache
// RAM requests; cctrans/ccwrite coherence requests; dwait/dload per-cache completion;
// ccwait/ccinv/ccsnoopaddr snoop controls; ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate RAM port.
module coherence_bus_ctrl
    import coherence_bus_ctrl_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic  [CPUS-1:0]     dREN,
    input  logic  [CPUS-1:0]     dWEN,
    input  word_t [CPUS-1:0]     daddr,
    input  word_t [CPUS-1:0]     dstore,
    input  logic  [CPUS-1:0]     cctrans,
    input  logic  [CPUS-1:0]     ccwrite,
    output logic  [CPUS-1:0]     dwait,
    output word_t [CPUS-1:0]     dload,
    output logic  [CPUS-1:0]     ccwait,
    output logic  [CPUS-1:0]     ccinv,
    output word_t [CPUS-1:0]     ccsnoopaddr,
    output logic                 ramREN,
    output logic                 ramWEN,
    output word_t                ramaddr,
    output word_t                ramstore,
    input  word_t                ramload,
    input  ramstate_t            ramstate
);
    localparam int CW = $clog2(BLKWORDS) + 1;
    bus_state_t    state, next_state;
    logic          owner, oth, reqwrite, acc, last, src;
    logic          gnt_valid, gnt_id, gnt_coh;
    word_t         snaddr;
    logic [CW-1:0] cnt, next_cnt;
    assign oth  = ~owner;
    assign acc  = ramstate == ACCESS;
    assign last = cnt == CW'(BLKWORDS - 1);
    rr_arbiter_2 u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .en        (state == IDLE),
        .creq      (cctrans),
        .preq      ((dREN | dWEN) & ~cctrans),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt_coh   (gnt_coh)
    );
    always_ff @(posedge CLK)
        if (RST) begin
            state    <= IDLE;
            owner    <= 1'b0;
            reqwrite <= 1'b0;
            snaddr   <= '0;
            cnt      <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (state == IDLE && gnt_valid) begin
                owner    <= gnt_id;
                reqwrite <= ccwrite[gnt_id];
                snaddr   <= daddr[gnt_id];
            end
        end
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE:  if (gnt_valid) next_state = gnt_coh ? SNOOP : PLAIN;
            SNOOP: next_state = ccwrite[oth] ? SWB : FILL;
            SWB: if (acc) begin
                next_cnt   = last ? '0 : cnt + CW'(1);
                next_state = last ? FILL : SWB;
            end
            // a dropped cctrans is an S->M upgrade that needs no data
            FILL: if (!cctrans[owner]) begin
                next_cnt   = '0;
                next_state = IDLE;
            end else if (acc) begin
                next_cnt   = last ? '0 : cnt + CW'(1);
                next_state = last ? IDLE : FILL;
            end
            PLAIN: if (!(dREN[owner] | dWEN[owner]) || acc) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end
    always_comb begin
        dwait       = '1;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        // the snooped cache owns the RAM port only while writing back its dirty line
        src         = (state == SWB) ? oth : owner;
        if (state == SNOOP || state == SWB) begin
            ccwait[oth]      = 1'b1;
            ccinv[oth]       = reqwrite;
            ccsnoopaddr[oth] = snaddr;
        end
        if (state == SWB || state == FILL || state == PLAIN) begin
            ramWEN     = dWEN[src];
            ramREN     = dREN[src] & ~dWEN[src] & (state != SWB);
            ramaddr    = daddr[src];
            ramstore   = dstore[src];
            dwait[src] = ~acc;
            if (state != SWB) dload[owner] = ramload;
        end
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed self-checking bench for coherence_bus_ctrl
module tb_coherence_bus_ctrl;
    import coherence_bus_ctrl_pkg::*;
    logic            CLK = 1'b0, RST;
    logic  [1:0]     dREN, dWEN, cctrans, ccwrite, dwait, ccwait, ccinv;
    word_t [1:0]     daddr, dstore, dload, ccsnoopaddr;
    logic            ramREN, ramWEN;
    word_t           ramaddr, ramstore, ramload;
    ramstate_t       ramstate;
    int              passed = 0, total = 0;

    coherence_bus_ctrl dut (
        .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite), .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        RST = 1'b1; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        tick(); tick();
        RST = 1'b0; #1;
        chk("rst_dwait", dwait, 2'b11);
        chk("rst_ccwait", ccwait, 2'b00);
        chk("rst_ren", ramREN, 1'b0);
        chk("rst_wen", ramWEN, 1'b0);
        chk("rst_addr", ramaddr, 32'h0);
        chk("rst_dload0", dload[0], 32'h0);
        chk("rst_snaddr1", ccsnoopaddr[1], 32'h0);

        // clean read miss from cache0
        cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h100; #1;
        chk("clean_idle_dwait", dwait, 2'b11);
        tick(); #1;
        chk("clean_snoop_ccwait", ccwait, 2'b10);
        chk("clean_snoop_ccinv", ccinv, 2'b00);
        chk("clean_snoop_addr", ccsnoopaddr[1], 32'h100);
        chk("clean_snoop_ren", ramREN, 1'b0);
        tick(); ramload = 32'hDEAD; #1;
        chk("clean_fill_ccwait", ccwait, 2'b00);
        chk("clean_fill_ren", ramREN, 1'b1);
        chk("clean_fill_addr", ramaddr, 32'h100);
        chk("clean_fill_wait_free", dwait, 2'b11);
        ramstate = ACCESS; #1;
        chk("clean_w0_dwait", dwait, 2'b10);
        chk("clean_w0_dload", dload[0], 32'hDEAD);
        tick(); daddr[0] = 32'h104; ramload = 32'hBEEF; #1;
        chk("clean_w1_addr", ramaddr, 32'h104);
        chk("clean_w1_dload", dload[0], 32'hBEEF);
        chk("clean_w1_dwait", dwait, 2'b10);
        tick(); cctrans = '0; dREN = '0; ramstate = FREE; #1;
        chk("clean_done_ren", ramREN, 1'b0);
        chk("clean_done_dwait", dwait, 2'b11);

        // dirty snoop: cache1 writes back before cache0 fill, then RAM stalls
        cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h100;
        tick(); ccwrite = 2'b10; dWEN = 2'b10; daddr[1] = 32'h100; dstore[1] = 32'h1111; #1;
        chk("dirty_snoop_ccwait", ccwait, 2'b10);
        chk("dirty_snoop_ccinv", ccinv, 2'b00);
        tick(); #1;
        chk("swb_wen", ramWEN, 1'b1);
        chk("swb_ren", ramREN, 1'b0);
        chk("swb_addr0", ramaddr, 32'h100);
        chk("swb_store0", ramstore, 32'h1111);
        chk("swb_dwait_free", dwait, 2'b11);
        chk("swb_ccwait", ccwait, 2'b10);
        ramstate = ACCESS; #1;
        chk("swb_dwait_acc0", dwait, 2'b01);
        tick(); daddr[1] = 32'h104; dstore[1] = 32'h2222; #1;
        chk("swb_addr1", ramaddr, 32'h104);
        chk("swb_store1", ramstore, 32'h2222);
        chk("swb_dwait_acc1", dwait, 2'b01);
        tick(); ramstate = BUSY; dWEN = '0; ccwrite = '0; #1;
        chk("dfill_ccwait", ccwait, 2'b00);
        chk("dfill_ren", ramREN, 1'b1);
        chk("dfill_wen", ramWEN, 1'b0);
        chk("dfill_addr", ramaddr, 32'h100);
        for (int i = 0; i < 5; i++) begin
            tick(); ramstate = (i == 4) ? ERROR : BUSY; #1;
            chk("busy_dwait", dwait, 2'b11);
            chk("busy_ren", ramREN, 1'b1);
        end
        ramstate = ACCESS; ramload = 32'hAAAA; #1;
        chk("dfill_w0_dload", dload[0], 32'hAAAA);
        chk("dfill_w0_dwait", dwait, 2'b10);
        tick(); ramstate = FREE; #1;
        chk("dfill_still_fill", ramREN, 1'b1);
        daddr[0] = 32'h104; ramstate = ACCESS; ramload = 32'hBBBB; #1;
        chk("dfill_w1_dload", dload[0], 32'hBBBB);
        tick(); cctrans = '0; dREN = '0; ramstate = FREE; #1;
        chk("dfill_done_dwait", dwait, 2'b11);
        chk("dfill_done_ren", ramREN, 1'b0);

        // write upgrade S->M: invalidate, no data
        cctrans = 2'b01; ccwrite = 2'b01;
        tick(); #1;
        chk("upg_ccinv", ccinv, 2'b10);
        chk("upg_ccwait", ccwait, 2'b10);
        tick(); cctrans = '0; ccwrite = '0; #1;
        chk("upg_fill_ren", ramREN, 1'b0);
        chk("upg_fill_wen", ramWEN, 1'b0);
        chk("upg_fill_ccwait", ccwait, 2'b00);
        tick();
        // simultaneous coherent requests with lastgrant=0
        cctrans = 2'b11; dREN = 2'b11; daddr[0] = 32'h200; daddr[1] = 32'h300; #1;
        chk("sim_idle_dwait", dwait, 2'b11);
        tick(); #1;
        chk("sim_first_ccwait", ccwait, 2'b01);
        chk("sim_first_snaddr", ccsnoopaddr[0], 32'h300);
        chk("sim_first_ccinv", ccinv, 2'b00);
        tick(); ramstate = ACCESS; ramload = 32'hCCCC; #1;
        chk("sim_fill1_addr", ramaddr, 32'h300);
        chk("sim_fill1_dload", dload[1], 32'hCCCC);
        chk("sim_fill1_dwait", dwait, 2'b01);
        tick(); tick(); cctrans = 2'b01; dREN = 2'b01; ramstate = FREE; #1;
        chk("sim_mid_dwait", dwait, 2'b11);
        tick(); #1;
        chk("sim_second_ccwait", ccwait, 2'b10);
        chk("sim_second_snaddr", ccsnoopaddr[1], 32'h200);
        tick(); cctrans = '0; dREN = '0;
        tick();

        // plain write from cache1 (lastgrant becomes 1)
        dWEN = 2'b10; daddr[1] = 32'h600; dstore[1] = 32'h6666;
        tick(); #1;
        chk("plain1_wen", ramWEN, 1'b1);
        chk("plain1_addr", ramaddr, 32'h600);
        chk("plain1_store", ramstore, 32'h6666);
        chk("plain1_ccwait", ccwait, 2'b00);
        chk("plain1_dwait_free", dwait, 2'b11);
        dREN = 2'b10; #1;
        chk("plain1_wen_wins", ramREN, 1'b0);
        ramstate = ACCESS; #1;
        chk("plain1_dwait_acc", dwait, 2'b01);
        tick(); dWEN = '0; dREN = '0; ramstate = FREE;

        // plain eviction cache0 vs coherent cache1: coherent wins despite round-robin
        dWEN = 2'b01; daddr[0] = 32'h400; dstore[0] = 32'h5555;
        cctrans = 2'b10; dREN = 2'b10; daddr[1] = 32'h500;
        tick(); #1;
        chk("prio_ccwait", ccwait, 2'b01);
        chk("prio_snaddr", ccsnoopaddr[0], 32'h500);
        tick(); cctrans = '0; dREN = '0; #1;
        chk("prio_fill_wen", ramWEN, 1'b0);
        tick(); #1;
        chk("prio_idle_dwait", dwait, 2'b11);
        tick(); #1;
        chk("evict_wen", ramWEN, 1'b1);
        chk("evict_addr", ramaddr, 32'h400);
        chk("evict_store", ramstore, 32'h5555);
        dWEN = '0;
        tick();

        // reset mid-SWB abandons the writeback and clears the word counter
        cctrans = 2'b01; dREN = 2'b01; daddr[0] = 32'h700;
        tick(); ccwrite = 2'b10; dWEN = 2'b10; daddr[1] = 32'h700; dstore[1] = 32'h7777;
        tick(); ramstate = ACCESS;
        tick(); RST = 1'b1; ramstate = FREE;
        tick(); tick(); RST = 1'b0; #1;
        chk("rswb_dwait", dwait, 2'b11);
        chk("rswb_ccwait", ccwait, 2'b00);
        chk("rswb_wen", ramWEN, 1'b0);
        tick(); tick(); ramstate = ACCESS; #1;
        chk("rswb_again_wen", ramWEN, 1'b1);
        chk("rswb_again_ccwait", ccwait, 2'b10);
        tick(); #1;
        chk("rswb_cnt_clear_ccwait", ccwait, 2'b10);
        chk("rswb_cnt_clear_wen", ramWEN, 1'b1);
        tick(); ramstate = FREE; dWEN = '0; ccwrite = '0; #1;
        chk("rswb_fill_ccwait", ccwait, 2'b00);
        chk("rswb_fill_ren", ramREN, 1'b1);
        cctrans = '0; dREN = '0;
        tick(); #1;
        chk("rswb_done_dwait", dwait, 2'b11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
